// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline control types: FSM state encoding
// and the XZR register index that never creates a hazard.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } ctrl_state_e;

  localparam int XZR = 31;

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// Load-use hazard term: a load in ID_EX writes a register
// that the instruction in IF_ID reads (XZR excluded).
// Ports: rn/rm/rd addresses, read-use flags, memread in;
// hazard out.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = XZR
) (
  input  logic [REG_ADDR_W-1:0] rn,
  input  logic [REG_ADDR_W-1:0] rm,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  uses_rn,
  input  logic                  uses_rm,
  input  logic                  memread,
  output logic                  hazard
);

  logic rn_hit;
  logic rm_hit;
  logic rd_real;

  assign rn_hit  = uses_rn && (rn == rd);
  assign rm_hit  = uses_rm && (rm == rd);
  assign rd_real = rd != REG_ADDR_W'(ZERO_REG);
  assign hazard  = memread && rd_real && (rn_hit || rm_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: PC write enable, pipeline register
// enables/flushes, memory-wait timeout flag, perf counters.
// Ports: clock/reset(active-low async), ID/EX hazard inputs,
// branch_taken_mem, mem_req/mem_ready in; pc_wren, wren_*,
// flush_*, mem_error, stall_count, flush_count, state out.
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int ZERO_REG          = XZR,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int MEM_TIMEOUT       = 64,
  parameter int COUNT_W           = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_uses_rm,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken_mem,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_wren,
  output logic                  wren_IF_ID,
  output logic                  wren_ID_EX,
  output logic                  wren_EX_MEM,
  output logic                  wren_MEM_WB,
  output logic                  flush_IF_ID,
  output logic                  flush_ID_EX,
  output logic                  flush_EX_MEM,
  output logic                  mem_error,
  output logic [COUNT_W-1:0]    stall_count,
  output logic [COUNT_W-1:0]    flush_count,
  output logic [1:0]            state
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  ctrl_state_e       state_q, state_d;
  logic [1:0]        load_q, load_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_d;
  logic              hazard;
  logic              branch_ev;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W),
    .ZERO_REG  (ZERO_REG)
  ) u_hazard_detect (
    .rn     (id_rn),
    .rm     (id_rm),
    .rd     (ex_rd),
    .uses_rn(id_uses_rn),
    .uses_rm(id_uses_rm),
    .memread(ex_memread),
    .hazard (hazard)
  );

  assign state = state_q;

  always_comb begin
    state_d      = state_q;
    load_d       = load_q;
    wait_d       = wait_q;
    err_d        = mem_error;
    branch_ev    = 1'b0;
    pc_wren      = 1'b1;
    wren_IF_ID   = 1'b1;
    wren_ID_EX   = 1'b1;
    wren_EX_MEM  = 1'b1;
    wren_MEM_WB  = 1'b1;
    flush_IF_ID  = 1'b0;
    flush_ID_EX  = 1'b0;
    flush_EX_MEM = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken_mem) begin
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          branch_ev    = 1'b1;
        end else if (mem_req && !mem_ready) begin
          pc_wren     = 1'b0;
          wren_IF_ID  = 1'b0;
          wren_ID_EX  = 1'b0;
          wren_EX_MEM = 1'b0;
          wren_MEM_WB = 1'b0;
          wait_d      = WAIT_W'(1);
          state_d     = MEM_WAIT;
        end else if (hazard) begin
          pc_wren     = 1'b0;
          wren_IF_ID  = 1'b0;
          flush_ID_EX = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            load_d  = 2'(LOAD_STALL_CYCLES - 1);
            state_d = LOAD_STALL;
          end
        end
      end
      LOAD_STALL: begin
        if (branch_taken_mem) begin
          flush_IF_ID  = 1'b1;
          flush_ID_EX  = 1'b1;
          flush_EX_MEM = 1'b1;
          branch_ev    = 1'b1;
          load_d       = 2'd0;
          state_d      = RUN;
        end else if (mem_req && !mem_ready) begin
          // freeze everything; remaining bubbles are kept
          pc_wren     = 1'b0;
          wren_IF_ID  = 1'b0;
          wren_ID_EX  = 1'b0;
          wren_EX_MEM = 1'b0;
          wren_MEM_WB = 1'b0;
        end else begin
          pc_wren     = 1'b0;
          wren_IF_ID  = 1'b0;
          flush_ID_EX = 1'b1;
          if (load_q <= 2'd1) begin
            load_d  = 2'd0;
            state_d = RUN;
          end else begin
            load_d = load_q - 2'd1;
          end
        end
      end
      MEM_WAIT: begin
        // branches cannot reach MEM here; ignored
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_q >= WAIT_W'(MEM_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = RUN;
        end else begin
          pc_wren     = 1'b0;
          wren_IF_ID  = 1'b0;
          wren_ID_EX  = 1'b0;
          wren_EX_MEM = 1'b0;
          wren_MEM_WB = 1'b0;
          wait_d      = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = RUN;
        load_d  = 2'd0;
      end
    endcase
    if (!reset) begin
      branch_ev    = 1'b0;
      pc_wren      = 1'b0;
      wren_IF_ID   = 1'b0;
      wren_ID_EX   = 1'b0;
      wren_EX_MEM  = 1'b0;
      wren_MEM_WB  = 1'b0;
      flush_IF_ID  = 1'b1;
      flush_ID_EX  = 1'b1;
      flush_EX_MEM = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      load_q      <= 2'd0;
      wait_q      <= '0;
      mem_error   <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      wait_q    <= wait_d;
      mem_error <= err_d;
      if (!pc_wren && stall_count != '1) begin
        stall_count <= stall_count + 1'b1;
      end
      if (branch_ev && flush_count != '1) begin
        flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench: two controllers (LOAD_STALL_CYCLES 1 and 2) on shared
// inputs, checked each cycle against a bubble/wait model.
module tb_pipeline_hazard_controller;

  localparam int N = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rn, id_rm, ex_rd;
  logic       id_uses_rn, id_uses_rm, ex_memread;
  logic       branch_taken_mem, mem_req, mem_ready;

  logic        pc_wren[N];
  logic        wren_IF_ID[N], wren_ID_EX[N];
  logic        wren_EX_MEM[N], wren_MEM_WB[N];
  logic        flush_IF_ID[N], flush_ID_EX[N];
  logic        flush_EX_MEM[N], mem_error[N];
  logic [15:0] stall_count[N], flush_count[N];
  logic [1:0]  state[N];

  int checks   = 0;
  int failures = 0;

  int m_bub[N];
  int m_wait[N];
  int m_err[N];
  int m_stall[N];
  int m_flush[N];

  always #5 clock = ~clock;

  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES(1)
  ) dut0 (
    .clock(clock), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken_mem(branch_taken_mem),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wren(pc_wren[0]),
    .wren_IF_ID(wren_IF_ID[0]), .wren_ID_EX(wren_ID_EX[0]),
    .wren_EX_MEM(wren_EX_MEM[0]), .wren_MEM_WB(wren_MEM_WB[0]),
    .flush_IF_ID(flush_IF_ID[0]), .flush_ID_EX(flush_ID_EX[0]),
    .flush_EX_MEM(flush_EX_MEM[0]), .mem_error(mem_error[0]),
    .stall_count(stall_count[0]), .flush_count(flush_count[0]),
    .state(state[0])
  );

  pipeline_hazard_controller #(
    .LOAD_STALL_CYCLES(2)
  ) dut1 (
    .clock(clock), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken_mem(branch_taken_mem),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_wren(pc_wren[1]),
    .wren_IF_ID(wren_IF_ID[1]), .wren_ID_EX(wren_ID_EX[1]),
    .wren_EX_MEM(wren_EX_MEM[1]), .wren_MEM_WB(wren_MEM_WB[1]),
    .flush_IF_ID(flush_IF_ID[1]), .flush_ID_EX(flush_ID_EX[1]),
    .flush_EX_MEM(flush_EX_MEM[1]), .mem_error(mem_error[1]),
    .stall_count(stall_count[1]), .flush_count(flush_count[1]),
    .state(state[1])
  );

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h",
             tag, idx, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs(input int i);
    return {pc_wren[i], wren_IF_ID[i], wren_ID_EX[i],
            wren_EX_MEM[i], wren_MEM_WB[i],
            flush_IF_ID[i], flush_ID_EX[i], flush_EX_MEM[i]};
  endfunction

  task automatic idle_inputs();
    id_rn = 5'd0; id_rm = 5'd0; ex_rd = 5'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0;
    ex_memread = 1'b0; branch_taken_mem = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Reset with busy inputs: outputs must still be cleared.
  task automatic do_reset();
    reset = 1'b0;
    ex_memread = 1'b1; ex_rd = 5'd3;
    id_rn = 5'd3; id_uses_rn = 1'b1;
    branch_taken_mem = 1'b1;
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      chk("rst_outs", i, outs(i), 32'h07);
      chk("rst_state", i, state[i], 0);
      chk("rst_err", i, mem_error[i], 0);
      chk("rst_stall", i, stall_count[i], 0);
      chk("rst_flush", i, flush_count[i], 0);
      m_bub[i] = 0; m_wait[i] = 0; m_err[i] = 0;
      m_stall[i] = 0; m_flush[i] = 0;
    end
    idle_inputs();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  // One clock: check against the model, then advance it.
  task automatic cycle();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      int lsc;
      int es;
      logic hz;
      logic [7:0] e;
      lsc = (i == 0) ? 1 : 2;
      hz = ex_memread && ex_rd != 5'd31 &&
           ((id_uses_rn && id_rn == ex_rd) ||
            (id_uses_rm && id_rm == ex_rd));
      es = m_wait[i] > 0 ? 2 : (m_bub[i] > 0 ? 1 : 0);
      chk("state", i, state[i], es);
      chk("stall_count", i, stall_count[i], m_stall[i]);
      chk("flush_count", i, flush_count[i], m_flush[i]);
      chk("mem_error", i, mem_error[i], m_err[i]);
      if (m_wait[i] > 0) begin
        if (mem_ready) begin
          e = 8'b11111_000; m_wait[i] = 0;
        end else if (m_wait[i] >= 64) begin
          e = 8'b11111_000; m_wait[i] = 0; m_err[i] = 1;
        end else begin
          e = 8'b00000_000; m_wait[i]++;
        end
      end else if (branch_taken_mem) begin
        e = 8'b11111_111; m_bub[i] = 0;
        if (m_flush[i] < 65535) m_flush[i]++;
      end else if (mem_req && !mem_ready) begin
        e = 8'b00000_000;
        if (m_bub[i] == 0) m_wait[i] = 1;
      end else if (m_bub[i] > 0 || hz) begin
        e = 8'b00111_010;
        if (m_bub[i] > 0) m_bub[i]--;
        else m_bub[i] = lsc - 1;
      end else begin
        e = 8'b11111_000;
      end
      chk("outs", i, outs(i), e);
      if (!e[7] && m_stall[i] < 65535) m_stall[i]++;
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [4:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(posedge clock); #1;
    do_reset();
    cycle(); cycle();

    // load-use on rn: 1 bubble vs 2 bubbles
    ex_memread = 1'b1; ex_rd = 5'd3;
    id_rn = 5'd3; id_uses_rn = 1'b1;
    cycle();
    idle_inputs();
    cycle(); cycle();
    chk("lu_stall_lsc1", 0, stall_count[0], 1);
    chk("lu_stall_lsc2", 1, stall_count[1], 2);

    // XZR destination never stalls
    ex_memread = 1'b1; ex_rd = 5'd31;
    id_rn = 5'd31; id_uses_rn = 1'b1;
    id_rm = 5'd31; id_uses_rm = 1'b1;
    cycle();
    // match on rm only
    ex_rd = 5'd7; id_rm = 5'd7; id_uses_rn = 1'b0;
    cycle();
    idle_inputs();
    cycle(); cycle();

    // branch beats a concurrent hazard
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd4;
    id_rn = 5'd4; id_uses_rn = 1'b1;
    branch_taken_mem = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("br_flush", 0, flush_count[0], 1);
    chk("br_nostall", 1, stall_count[1], 0);

    // 4-cycle memory wait
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (4) cycle();
    mem_ready = 1'b1;
    cycle();
    idle_inputs();
    cycle();
    chk("mw_stall", 0, stall_count[0], 4);
    chk("mw_err", 0, mem_error[0], 0);

    // timeout: 64 frozen cycles, then forced release
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    repeat (65) cycle();
    mem_req = 1'b0;
    repeat (5) cycle();
    chk("to_err", 0, mem_error[0], 1);
    chk("to_stall", 1, stall_count[1], 64);
    chk("to_state", 0, state[0], 0);
    do_reset();
    chk("to_err_clr", 1, mem_error[1], 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ex_memread = 1'($urandom_range(0, 1));
      ex_rd = rnd_reg();
      id_rn = rnd_reg();
      id_rm = rnd_reg();
      id_uses_rn = 1'($urandom_range(0, 1));
      id_uses_rm = 1'($urandom_range(0, 1));
      branch_taken_mem = ($urandom_range(0, 9) == 0);
      mem_req = ($urandom_range(0, 5) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
